mips_debug_display: RTL and testbench

Board-level debug display stage directly downstream of the single-cycle MIPS SoC. It consumes the core's architectural probe outputs (PC, instruction, ALU result, write-back value) and presents one 16-bit page at a time on a 4-digit, common-anode, multiplexed seven-segment display. A debounced push-button steps through the pages. The block is purely an observer: it never drives anything back into the core.

---
 rtl/mips_dbg_pkg.sv | 24 ++
 rtl/mips_debug_display_btn_debounce.sv | 65 ++++++
 rtl/mips_debug_display.sv | 103 ++++++++++
 tb/tb_mips_debug_display.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_dbg_pkg.sv
// Shared constants for the MIPS debug display: page encoding and the
// active-low hex-to-seven-segment glyph table.
package mips_dbg_pkg;

  typedef enum logic [1:0] {
    PAGE_PC    = 2'd0,
    PAGE_IHI   = 2'd1,
    PAGE_ILO   = 2'd2,
    PAGE_ALUWB = 2'd3
  } page_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Segment order {g,f,e,d,c,b,a}; a zero lights the segment.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    return HEX_SEG[nibble];
  endfunction

endpackage

// File: rtl/mips_debug_display_btn_debounce.sv
// Push-button conditioner: two-flop synchronizer, debounce counter and a
// one-cycle pulse on each accepted press; a button held through reset is ignored.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic rise_o
);

  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q, sync2_q;
  logic          acc_q, acc_d;
  logic          armed_q, armed_d;
  logic          rise_q, rise_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Until a debounced release is seen the block is unarmed, so a level that
  // was already high when reset lifted never counts as a press.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    armed_d = armed_q;
    acc_d   = acc_q;
    cnt_d   = '0;
    rise_d  = 1'b0;
    if (!armed_q) begin
      if (!sync2_q) begin
        if (cnt_q == LAST) armed_d = 1'b1;
        else               cnt_d   = cnt_q + CW'(1);
      end
    end else if (sync2_q != acc_q) begin
      if (cnt_q == LAST) begin
        acc_d  = sync2_q;
        rise_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      acc_q   <= 1'b0;
      armed_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
      acc_q   <= acc_d;
      armed_q <= armed_d;
      rise_q  <= rise_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rise_o = rise_q;

endmodule

// File: rtl/mips_debug_display.sv
// Four-digit multiplexed seven-segment viewer for the MIPS core probes.
// Define MIPS_DBG_BLANK_LZ_EN to blank leading-zero digits 3..1.
module mips_debug_display
  import mips_dbg_pkg::*;
#(
  parameter int PC_WIDTH        = 6,
  parameter int ALU_WIDTH       = 8,
  parameter int REG_WIDTH       = 8,
  parameter int SCAN_BITS       = 16,
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 btn_next,
  input  logic [PC_WIDTH-1:0]  PCout,
  input  logic [31:0]          Instruction,
  input  logic [ALU_WIDTH-1:0] ALUResult,
  input  logic [REG_WIDTH-1:0] WriteBack,
  output logic [3:0]           an,
  output logic [6:0]           seg,
  output logic                 dp,
  output logic [1:0]           page
);

  logic [SCAN_BITS-1:0] scan_q, scan_d;
  logic [1:0]           digit_q, digit_d;
  logic [15:0]          frame_q, frame_d;
  page_e                page_q, page_d;
  logic [3:0]           an_q, an_d;
  logic [6:0]           seg_q, seg_d;
  logic                 dp_q, dp_d;

  logic        btn_rise;
  logic [15:0] src;
  logic [3:0]  nibble;
  logic        lz_blank;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_btn (
    .clk    (clk),
    .rst    (rst),
    .btn_i  (btn_next),
    .rise_o (btn_rise)
  );

  always_comb begin
    src = '0;
    case (page_q)
      PAGE_PC:    src = 16'(PCout);
      PAGE_IHI:   src = Instruction[31:16];
      PAGE_ILO:   src = Instruction[15:0];
      PAGE_ALUWB: src = 16'({ALUResult, WriteBack});
      default:    src = '0;
    endcase
  end

  assign nibble = frame_q[{digit_q, 2'b00} +: 4];

`ifdef MIPS_DBG_BLANK_LZ_EN
  assign lz_blank = (digit_q != 2'd0) && ((frame_q >> {digit_q, 2'b00}) == 16'h0000);
`else
  assign lz_blank = 1'b0;
`endif

  // The frame only reloads at the start of digit 0, so all four digits
  // shown in one sweep come from the same sample.
  always_comb begin
    scan_d  = scan_q + SCAN_BITS'(1);
    digit_d = (&scan_q) ? digit_q + 2'd1 : digit_q;
    frame_d = (scan_q == '0 && digit_q == 2'd0) ? src : frame_q;
    page_d  = btn_rise ? page_e'(page_q + 2'd1) : page_q;
    an_d    = ~(4'b0001 << digit_q);
    seg_d   = lz_blank ? SEG_BLANK : hex_to_seg(nibble);
    dp_d    = (digit_q != page_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_q  <= '0;
      digit_q <= 2'd0;
      frame_q <= 16'h0000;
      page_q  <= PAGE_PC;
      an_q    <= 4'b1111;
      seg_q   <= SEG_BLANK;
      dp_q    <= 1'b1;
    end else begin
      scan_q  <= scan_d;
      digit_q <= digit_d;
      frame_q <= frame_d;
      page_q  <= page_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
    end
  end

  assign an   = an_q;
  assign seg  = seg_q;
  assign dp   = dp_q;
  assign page = page_q;

endmodule

// File: tb/tb_mips_debug_display.sv
// Self-checking bench for mips_debug_display with a time-indexed display
// model and a run-length button model, plus directed scenario checks.
module tb_mips_debug_display;

  localparam int SB  = 2;
  localparam int DB  = 4;
  localparam int FRM = 1 << (SB + 2);

  logic        clk = 1'b0;
  logic        rst;
  logic        btn_next;
  logic [5:0]  PCout;
  logic [31:0] Instruction;
  logic [7:0]  ALUResult, WriteBack;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic [1:0]  page;

  always #5 clk = ~clk;

  mips_debug_display #(
    .PC_WIDTH        (6),
    .ALU_WIDTH       (8),
    .REG_WIDTH       (8),
    .SCAN_BITS       (SB),
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_next    (btn_next),
    .PCout       (PCout),
    .Instruction (Instruction),
    .ALUResult   (ALUResult),
    .WriteBack   (WriteBack),
    .an          (an),
    .seg         (seg),
    .dp          (dp),
    .page        (page)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", tag, act, exp);
    end
  endtask

  // Lit segments {g..a}, active-high; the display wants the inverse.
  localparam logic [6:0] LIT [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  function automatic logic [6:0] exp_seg(input logic [15:0] f, input int d);
    logic [3:0] nib;
    nib = 4'((f >> (4 * d)) & 16'hF);
`ifdef MIPS_DBG_BLANK_LZ_EN
    if (d > 0 && (f >> (4 * d)) == 16'h0) return 7'h7F;
`endif
    return ~LIT[nib];
  endfunction

  function automatic logic [15:0] page_src(input int pg);
    case (pg)
      0:       return {10'h000, PCout};
      1:       return Instruction[31:16];
      2:       return Instruction[15:0];
      default: return {ALUResult, WriteBack};
    endcase
  endfunction

  // Model state
  int          m_n;
  logic [15:0] m_frame;
  int          m_page;
  bit          m_step, m_armed, m_acc;
  int          m_run;
  bit          hist[$];
  int          steps_seen, last_step_edge;
  logic [1:0]  prev_page;

  task automatic model_edge();
    int         t, d;
    bit         lvl;
    logic [3:0] ea;
    t  = m_n;
    m_n++;
    d  = (t >> SB) % 4;
    ea = 4'b1111;
    ea[d] = 1'b0;
    check("an",  32'(an),  32'(ea));
    check("seg", 32'(seg), 32'(exp_seg(m_frame, d)));
    check("dp",  32'(dp),  (d == m_page) ? 32'd0 : 32'd1);
    if (t % FRM == 0) m_frame = page_src(m_page);
    if (m_step) m_page = (m_page + 1) % 4;
    m_step = 1'b0;
    // Synchronized level lags the pin by two edges; treated as high until known.
    lvl = (hist.size() >= 2) ? hist[hist.size() - 2] : 1'b1;
    hist.push_back(btn_next);
    if (hist.size() > 2) void'(hist.pop_front());
    if (!m_armed) begin
      m_run = lvl ? 0 : m_run + 1;
      if (m_run == DB) begin m_armed = 1'b1; m_run = 0; end
    end else if (lvl != m_acc) begin
      m_run++;
      if (m_run == DB) begin m_acc = lvl; m_run = 0; m_step = lvl; end
    end else begin
      m_run = 0;
    end
    check("page", 32'(page), 32'(m_page));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    model_edge();
    if (page !== prev_page) begin steps_seen++; last_step_edge = m_n; end
    prev_page = page;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_an",   32'(an),   32'hF);
    check("rst_seg",  32'(seg),  32'h7F);
    check("rst_dp",   32'(dp),   32'h1);
    check("rst_page", 32'(page), 32'h0);
    m_n = 0; m_frame = 16'h0; m_page = 0; m_step = 0; m_armed = 0; m_acc = 0; m_run = 0;
    hist.delete();
    prev_page = 2'd0;
  endtask

  // Sweeps one complete freshly loaded frame and compares it to spec constants.
  task automatic show_frame(input string tag, input logic [15:0] val, input int pg);
    tick();
    while (m_n % FRM != 1) tick();
    for (int k = 0; k < FRM; k++) begin
      int         d;
      logic [3:0] ea;
      tick();
      d  = ((k + 1) >> SB) % 4;
      ea = 4'b1111;
      ea[d] = 1'b0;
      check({tag, "_an"},  32'(an),  32'(ea));
      check({tag, "_seg"}, 32'(seg), 32'(exp_seg(val, d)));
      check({tag, "_dp"},  32'(dp),  (d == pg) ? 32'd0 : 32'd1);
    end
  endtask

  task automatic press(input int hold, input int rel);
    btn_next = 1'b1;
    repeat (hold) tick();
    btn_next = 1'b0;
    repeat (rel) tick();
  endtask

  initial begin
    int press_edge;
    int pats [7];
    int exp_seq [4];
    rst = 1'b1; btn_next = 1'b0;
    PCout = 6'h2A; Instruction = 32'h8C410004; ALUResult = 8'h05; WriteBack = 8'hFF;
    steps_seen = 0; last_step_edge = 0; prev_page = 2'd0;
    do_reset();

    // Idle on page 0
    show_frame("pc", 16'h002A, 0);

    // Clean held press
    steps_seen = 0;
    press_edge = m_n + 1;
    press(10, 12);
    check("press_latency", 32'(last_step_edge - press_edge + 1), 32'd7);
    check("press_steps",   32'(steps_seen), 32'd1);
    show_frame("ihi", 16'h8C41, 1);

    // Bounce 1,1,0,1,1,1,1 then held
    pats = '{1, 1, 0, 1, 1, 1, 1};
    steps_seen = 0;
    press_edge = m_n + 1;
    foreach (pats[i]) begin btn_next = pats[i][0]; tick(); end
    repeat (6) tick();
    btn_next = 1'b0;
    repeat (12) tick();
    check("bounce_steps",   32'(steps_seen), 32'd1);
    check("bounce_latency", 32'(last_step_edge - press_edge), 32'd9);

    // Four clean presses from page 0
    do_reset();
    repeat (12) tick();
    exp_seq = '{1, 2, 3, 0};
    for (int i = 0; i < 4; i++) begin
      press(6, 12);
      check("seq_page", 32'(page), 32'(exp_seq[i]));
      if (i == 2) show_frame("aluwb", 16'h05FF, 3);
    end

    // Reset mid-frame while on page 2
    press(6, 12);
    press(6, 12);
    while (m_n % FRM != 6) tick();
    check("pre_rst_page", 32'(page), 32'd2);
    do_reset();

    // Button held through reset is ignored until released
    repeat (12) tick();
    btn_next = 1'b1;
    repeat (3) tick();
    do_reset();
    steps_seen = 0;
    repeat (20) tick();
    check("held_rst_steps", 32'(steps_seen), 32'd0);
    btn_next = 1'b0;
    repeat (12) tick();
    press(6, 12);
    check("repress_page", 32'(page), 32'd1);

    // Leading-zero patterns on page 0
    do_reset();
    PCout = 6'h03;
    show_frame("pc03", 16'h0003, 0);
    PCout = 6'h00;
    show_frame("pc00", 16'h0000, 0);

    // Randomized sources and button activity
    for (int s = 0; s < 90; s++) begin
      int len;
      btn_next = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 9);
      repeat (len) begin
        PCout       = 6'($urandom);
        Instruction = $urandom;
        ALUResult   = 8'($urandom);
        WriteBack   = 8'($urandom);
        tick();
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
